// File: rtl/lsu_mw.sv
// lsu_mw: memory/writeback load-store unit; runs loads/stores as req/ack bus
// transactions, stalls the pipeline meanwhile and selects the writeback value.
module lsu_mw #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_op_mw,
    input  logic [31:0] alu_mw,
    input  logic [31:0] data_wr_mw,
    input  logic [31:0] pc_mw,
    input  logic [1:0]  wb_sel_mw,
    input  logic        rf_wr_mw,
    input  logic [31:0] csr_rdata,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        stall_mw,
    output logic [31:0] wdata_wb,
    output logic        rf_wr_en,
    output logic        misalign_mw,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t      r_state, w_next;
    logic [7:0]  r_cnt;
    logic        r_req, r_we, r_to;
    logic [31:0] r_addr, r_wdata, r_ld_buf;
    logic [3:0]  r_be;

    logic        w_ld, w_st, w_mem, w_legal, w_access, w_mis, w_go;
    logic [2:0]  w_f3;
    logic [1:0]  w_off;
    logic [31:0] w_shift, w_ext, w_st_data, w_wb;
    logic [3:0]  w_st_be;

    assign w_ld     = mem_op_mw[4];
    assign w_st     = mem_op_mw[3];
    assign w_f3     = mem_op_mw[2:0];
    assign w_off    = alu_mw[1:0];
    assign w_mem    = w_ld | w_st;
    assign w_legal  = (w_f3 == 3'b000) | (w_f3 == 3'b001) | (w_f3 == 3'b010) |
                      (w_f3 == 3'b100) | (w_f3 == 3'b101);
    assign w_access = (w_ld ^ w_st) & w_legal;
    assign w_mis    = ((w_f3[1:0] == 2'b01) & w_off[0]) | ((w_f3[1:0] == 2'b10) & (|w_off));
    assign w_go     = w_access & ~w_mis;

    assign w_st_data = (w_f3[1:0] == 2'b00) ? {4{data_wr_mw[7:0]}} :
                       (w_f3[1:0] == 2'b01) ? {2{data_wr_mw[15:0]}} : data_wr_mw;
    assign w_st_be   = (w_f3[1:0] == 2'b00) ? (4'b0001 << w_off) :
                       (w_f3[1:0] == 2'b01) ? (w_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    // Address and funct3 stay valid while stalled, so they steer load extraction.
    assign w_shift = dbus_rdata >> {w_off, 3'b000};
    assign w_ext   = (w_f3 == 3'b000) ? {{24{w_shift[7]}}, w_shift[7:0]} :
                     (w_f3 == 3'b001) ? {{16{w_shift[15]}}, w_shift[15:0]} :
                     (w_f3 == 3'b100) ? {24'b0, w_shift[7:0]} :
                     (w_f3 == 3'b101) ? {16'b0, w_shift[15:0]} : w_shift;

    assign w_wb = (wb_sel_mw == 2'd0) ? alu_mw :
                  (wb_sel_mw == 2'd1) ? r_ld_buf :
                  (wb_sel_mw == 2'd2) ? pc_mw + 32'd4 : csr_rdata;

    assign dbus_req   = r_req;
    assign dbus_we    = r_we;
    assign dbus_addr  = r_addr;
    assign dbus_wdata = r_wdata;
    assign dbus_be    = r_be;
    assign wdata_wb   = rst ? 32'd0 : w_wb;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        stall_mw    = 1'b0;
        rf_wr_en    = 1'b0;
        misalign_mw = 1'b0;
        bus_err     = 1'b0;
        case (r_state)
            IDLE: begin
                stall_mw    = w_go;
                misalign_mw = w_access & w_mis;
                rf_wr_en    = rf_wr_mw & ~w_mem;
                w_next      = w_go ? BUSY : IDLE;
            end
            BUSY: begin
                stall_mw = 1'b1;
                w_next   = (dbus_ack || r_cnt == LAST) ? DONE : BUSY;
            end
            DONE: begin
                rf_wr_en = rf_wr_mw & ~r_to;
                bus_err  = r_to;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (rst) begin
            stall_mw    = 1'b0;
            rf_wr_en    = 1'b0;
            misalign_mw = 1'b0;
            bus_err     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_to     <= 1'b0;
            r_cnt    <= 8'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_be     <= 4'd0;
            r_ld_buf <= 32'd0;
        end else if (r_state == IDLE && w_go) begin
            r_req   <= 1'b1;
            r_we    <= w_st;
            r_to    <= 1'b0;
            r_cnt   <= 8'd0;
            r_addr  <= {alu_mw[31:2], 2'b00};
            r_wdata <= w_st_data;
            r_be    <= w_st_be;
        end else if (r_state == BUSY) begin
            if (dbus_ack) begin
                r_req <= 1'b0;
                if (w_ld) r_ld_buf <= w_ext;
            end else if (r_cnt == LAST) begin
                r_req    <= 1'b0;
                r_ld_buf <= 32'd0;
                r_to     <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end
endmodule

// File: doc/lsu_mw.md
# lsu_mw

Memory/writeback stage load-store unit. It consumes the outputs of the decode/execute-to-memory/writeback pipeline register (`*_mw` signals) and runs each load or store as a req/ack transaction on the data bus. While a transaction is in flight it stalls the pipeline. It then extracts and extends load data and selects the final register-file write value.

## Interface

Parameters:
- `TIMEOUT`, 255: maximum `BUSY` cycles without `dbus_ack` before the access is abandoned with `bus_err`. Legal range 1..255. The counter is 8 bits.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_op_mw` in 5: `[4]` load, `[3]` store, `[2:0]` funct3. funct3 encodings: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `alu_mw` in 32: effective address, or ALU result for writeback.
- `data_wr_mw` in 32: store source data.
- `pc_mw` in 32: instruction PC.
- `wb_sel_mw` in 2: writeback select. 0 alu, 1 load, 2 pc+4, 3 csr.
- `rf_wr_mw` in 1: the instruction writes rd.
- `csr_rdata` in 32: CSR read value.
- `dbus_req` out 1: registered transaction request.
- `dbus_we` out 1: registered, 1 = store.
- `dbus_addr` out 32: registered, `{alu_mw[31:2],2'b00}`.
- `dbus_wdata` out 32: registered, lane-replicated store data.
- `dbus_be` out 4: registered byte enables.
- `dbus_rdata` in 32: read data, valid with `dbus_ack`.
- `dbus_ack` in 1: single-cycle completion pulse.
- `stall_mw` out 1: holds the PC, the fetch register and `reg_de_mw` contents.
- `wdata_wb` out 32: register-file write data.
- `rf_wr_en` out 1: qualified register-file write enable.
- `misalign_mw` out 1: misaligned access flag, one cycle.
- `bus_err` out 1: timeout flag, one cycle.

## Operation

- **Access condition:** exactly one of `mem_op_mw[4:3]` is set and funct3 is legal.
  - Illegal funct3, or both bits set: treated as a no-op. No bus access and `rf_wr_en=0`.
- **Misaligned:**
  - h/hu with `addr[0]=1`.
  - w with `addr[1:0]!=0`.
  - b is never misaligned.
  - On misalignment: no bus access, no stall, `misalign_mw=1` and `rf_wr_en=0` in that cycle.
- **FSM states:** `IDLE`, `BUSY`, `DONE`.
  - `IDLE`: an aligned access sets `stall_mw=1` combinationally. At the clock edge, drive `dbus_req=1` and latch we/addr/wdata/be, clear the counter, and move to `BUSY`.
  - `BUSY`: bus outputs are held stable and `stall_mw=1`.
    - On `dbus_ack`: capture the extended load data into `ld_buf` (loads only), drop `dbus_req`, and move to `DONE`.
    - If the counter reaches `TIMEOUT` without ack: drop `dbus_req`, set `ld_buf=0`, arm `bus_err`, and move to `DONE`.
  - `DONE`: `stall_mw=0`. `rf_wr_en=rf_wr_mw` unless timed out, in which case `bus_err=1` and `rf_wr_en=0`. Next state is `IDLE`.
- **`rf_wr_en`:**
  - Non-access instructions: `rf_wr_en=rf_wr_mw` in `IDLE`.
  - Access instructions: forced to 0 in `IDLE` and `BUSY`.
- **Store lanes:**
  - sb: wdata = `{4{d[7:0]}}`, be = `4'b0001<<addr[1:0]`.
  - sh: wdata = `{2{d[15:0]}}`, be = `addr[1]?1100:0011`.
  - sw: wdata = d, be = 1111.
- **Loads:**
  - Shift `dbus_rdata` right by `8*addr[1:0]`.
  - b/h: sign-extend bit 7/15.
  - bu/hu: zero-extend.
  - w: unchanged.
- **Writeback mux:**
  - 0 → `alu_mw`
  - 1 → `ld_buf`
  - 2 → `pc_mw+32'd4`, modulo 2^32
  - 3 → `csr_rdata`
- `dbus_ack` is ignored outside `BUSY`.

## Timing

- **Latency:**
  - Minimum access occupancy is 3 cycles: `IDLE` detect, `BUSY` with ack in the first `BUSY` cycle, then `DONE`.
  - Stall cycles = 1 + (cycles in `BUSY`).
  - Non-memory instructions have zero added latency.
- **Ack timing:** ack may arrive in the first `BUSY` cycle. `BUSY` lasts at most `TIMEOUT` cycles.
- **Reset:** in the cycle after `rst` is sampled high:
  - state is `IDLE`.
  - `dbus_req`, `dbus_we` and `dbus_be` are 0, and `dbus_addr`, `dbus_wdata`, `ld_buf` and the counter are 0.
  - `stall_mw`, `rf_wr_en`, `misalign_mw` and `bus_err` are 0.
- **Reset mid-transaction:** abandons the access at the next edge, and a late ack is ignored.
- **Combinational outputs:** `stall_mw`, `rf_wr_en`, `misalign_mw` and `wdata_wb` are combinational from state and the `*_mw` inputs. They are forced to 0 while `rst` is high.
- `dbus_*` outputs change only at clock edges.

## Test plan

- **Store byte:** `sb`, addr 0x103, data 0xA5 → `dbus_be=1000`, `wdata=0xA5A5A5A5`, `addr=0x100`. With ack on the first `BUSY` cycle, `stall_mw` is high exactly 2 cycles and `rf_wr_en` stays 0.
- **Signed/unsigned halfword loads:** `lh` at 0x202 with rdata 0x8001_1234 → `wdata_wb=0xFFFF8001` and `rf_wr_en=1` in `DONE` only. `lhu` at the same address → 0x00008001.
- **Misaligned word:** `lw` at 0x305 → `misalign_mw=1` for 1 cycle, no `dbus_req`, no stall, `rf_wr_en=0`.
- **Timeout:** `TIMEOUT=4` and no ack → `dbus_req` high 4 cycles, then `bus_err=1` for one cycle, `rf_wr_en=0`, and `IDLE` next.
- **Writeback mux:** `wb_sel=2` with `pc=0xFFFFFFFC` → `wdata_wb=0x00000000`. `wb_sel=3` → `csr_rdata`. Neither case stalls.
- **Reset mid-transaction:** `rst` during `BUSY` → `dbus_req=0` after the edge, then ack arrives 2 cycles later → no state change and no `rf_wr_en`.
